// File: rtl/brew_sequencer.sv
// rtl/brew_sequencer.sv - recipe-driven brew stage sequencer for the coffee machine datapath
//
// Purpose:
//   On start, walks GRIND -> HEAT -> BREW -> MILK -> DISPENSE for the latched drink,
//   skipping stages with zero duration, then spends one cycle in DONE before IDLE.
//   Stage time is counted in prescaled ticks produced by a clock-enable prescaler.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   begin a brew of coffee_type (IDLE only)
//   abort        in   terminate an active brew (GRIND..DISPENSE)
//   coffee_type  in   0 espresso, 1 americano, 2 cappuccino, 3 latte
//   busy         out  high in every state except IDLE
//   stage        out  current state code
//   actuator     out  one-hot {dispense, milk, pump, heater, grinder}, 0 outside stages
//   remaining    out  ticks left in the current stage, 0 in IDLE/DONE
//   step_tick    out  prescaler tick
//   done         out  one-cycle pulse on normal completion
//   aborted      out  one-cycle pulse on abort

module brew_sequencer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       coffee_type,
    output logic             busy,
    output logic [2:0]       stage,
    output logic [4:0]       actuator,
    output logic [CNT_W-1:0] remaining,
    output logic             step_tick,
    output logic             done,
    output logic             aborted
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GRIND    = 3'd1;
    localparam logic [2:0] ST_HEAT     = 3'd2;
    localparam logic [2:0] ST_BREW     = 3'd3;
    localparam logic [2:0] ST_MILK     = 3'd4;
    localparam logic [2:0] ST_DISPENSE = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

    localparam logic [1:0] TYPE_ESPRESSO   = 2'd0;
    localparam logic [1:0] TYPE_AMERICANO  = 2'd1;
    localparam logic [1:0] TYPE_CAPPUCCINO = 2'd2;
    localparam logic [1:0] TYPE_LATTE      = 2'd3;

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    logic [2:0]         state_q,   state_d;
    logic [PRESC_W-1:0] presc_q,   presc_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [1:0]         type_q,    type_d;
    logic               aborted_q, aborted_d;

    logic               in_stage;
    logic               tick;
    logic [2:0]         nxt_stage;

    // Recipe table: duration in ticks of stage s for drink t (0 = stage skipped).
    function automatic logic [CNT_W-1:0] stage_dur(input logic [1:0] t, input logic [2:0] s);
        logic [CNT_W-1:0] d;
        d = '0;
        case (s)
            ST_GRIND:    d = CNT_W'(3);
            ST_HEAT:     d = CNT_W'(2);
            ST_BREW:     d = (t == TYPE_AMERICANO) ? CNT_W'(6) : CNT_W'(4);
            ST_MILK: begin
                case (t)
                    TYPE_CAPPUCCINO: d = CNT_W'(4);
                    TYPE_LATTE:      d = CNT_W'(6);
                    default:         d = '0;
                endcase
            end
            ST_DISPENSE: d = (t == TYPE_AMERICANO || t == TYPE_LATTE) ? CNT_W'(3) : CNT_W'(2);
            default:     d = '0;
        endcase
        return d;
    endfunction

    // First stage after cur with a nonzero duration; DONE when none remain.
    // Scanning downwards lets the lowest qualifying stage overwrite the result last.
    function automatic logic [2:0] next_stage(input logic [1:0] t, input logic [2:0] cur);
        logic [2:0] n;
        n = ST_DONE;
        for (int s = 5; s >= 1; s--) begin
            if (3'(s) > cur && stage_dur(t, 3'(s)) != '0) begin
                n = 3'(s);
            end
        end
        return n;
    endfunction

    assign in_stage = (state_q >= ST_GRIND) && (state_q <= ST_DISPENSE);
    assign tick     = in_stage && (presc_q == PRESC_MAX);

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        type_d    = type_q;
        aborted_d = 1'b0;
        nxt_stage = ST_DONE;

        case (state_q)
            ST_IDLE: begin
                // abort outranks start here: stay idle without raising any pulse
                if (start && !abort) begin
                    nxt_stage = next_stage(coffee_type, ST_IDLE);
                    state_d   = nxt_stage;
                    type_d    = coffee_type;
                    cnt_d     = stage_dur(coffee_type, nxt_stage);
                    presc_d   = '0;
                end
            end

            ST_GRIND, ST_HEAT, ST_BREW, ST_MILK, ST_DISPENSE: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    presc_d   = '0;
                    aborted_d = 1'b1;
                end else begin
                    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
                    if (tick) begin
                        // <= 1 rather than == 1 keeps the counter from ever wrapping
                        if (cnt_q <= CNT_W'(1)) begin
                            nxt_stage = next_stage(type_q, state_q);
                            state_d   = nxt_stage;
                            cnt_d     = (nxt_stage == ST_DONE) ? '0 : stage_dur(type_q, nxt_stage);
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                presc_d = '0;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                presc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            cnt_q     <= '0;
            type_q    <= TYPE_ESPRESSO;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            type_q    <= type_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        actuator = 5'b00000;
        case (state_q)
            ST_GRIND:    actuator = 5'b00001;
            ST_HEAT:     actuator = 5'b00010;
            ST_BREW:     actuator = 5'b00100;
            ST_MILK:     actuator = 5'b01000;
            ST_DISPENSE: actuator = 5'b10000;
            default:     actuator = 5'b00000;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign stage     = state_q;
    assign remaining = in_stage ? cnt_q : '0;
    assign step_tick = tick;
    assign done      = (state_q == ST_DONE);
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_brew_sequencer.sv
// tb/tb_brew_sequencer.sv - scoreboard bench for brew_sequencer with TICK_DIV=2

module tb_brew_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [1:0] coffee_type;
    logic       busy;
    logic [2:0] stage;
    logic [4:0] actuator;
    logic [3:0] remaining;
    logic       step_tick;
    logic       done;
    logic       aborted;

    brew_sequencer #(.TICK_DIV(2), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .coffee_type (coffee_type),
        .busy        (busy),
        .stage       (stage),
        .actuator    (actuator),
        .remaining   (remaining),
        .step_tick   (step_tick),
        .done        (done),
        .aborted     (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic [2:0] stage;
        logic [4:0] act;
        logic [3:0] rem;
        logic       tick;
        logic       done;
        logic       ab;
    } exp_t;

    exp_t expq[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // G/H/B/M/D durations in ticks per drink
    int rec [4][5] = '{'{3, 2, 4, 0, 2},
                       '{3, 2, 6, 0, 3},
                       '{3, 2, 4, 4, 2},
                       '{3, 2, 4, 6, 3}};

    function automatic exp_t idle_vec();
        exp_t e;
        e = '0;
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.busy  = busy;
        o.stage = stage;
        o.act   = actuator;
        o.rem   = remaining;
        o.tick  = step_tick;
        o.done  = done;
        o.ab    = aborted;
        return o;
    endfunction

    // cut_kind: 0 runs to completion, 1 aborts after entry cut_idx, 2 resets after entry cut_idx
    task automatic build(input int t, input int cut_idx, input int cut_kind);
        exp_t e;
        int   n;
        n = 0;
        for (int s = 1; s <= 5; s++) begin
            for (int r = rec[t][s-1]; r >= 1; r--) begin
                for (int h = 0; h < 2; h++) begin
                    if (cut_kind == 0 || n <= cut_idx) begin
                        e       = '0;
                        e.busy  = 1'b1;
                        e.stage = 3'(s);
                        e.act   = 5'(1 << (s - 1));
                        e.rem   = 4'(r);
                        e.tick  = (h == 1);
                        expq.push_back(e);
                    end
                    n++;
                end
            end
        end
        if (cut_kind == 0) begin
            e       = '0;
            e.busy  = 1'b1;
            e.stage = 3'd6;
            e.done  = 1'b1;
            expq.push_back(e);
        end else if (cut_kind == 1) begin
            e    = '0;
            e.ab = 1'b1;
            expq.push_back(e);
        end else begin
            expq.push_back(idle_vec());
        end
        expq.push_back(idle_vec());
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts drink t, then compares one scoreboard entry per cycle while applying
    // per-cycle side stimulus (abort/reset cut, mid-brew start, abort during DONE).
    task automatic run_brew(input string name, input int t, input int cut_idx, input int cut_kind,
                            input int ms_idx, input int ms_type, input int xa_idx);
        exp_t exp_v;
        exp_t obs;
        int   c;
        build(t, cut_idx, cut_kind);
        start       = 1'b1;
        coffee_type = 2'(t);
        step();
        start = 1'b0;
        c     = 0;
        while (expq.size() > 0 && c < 200) begin
            exp_v = expq.pop_front();
            obs   = observed();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got busy=%b stage=%0d act=%b rem=%0d tick=%b done=%b ab=%b, expected busy=%b stage=%0d act=%b rem=%0d tick=%b done=%b ab=%b",
                         name, c, obs.busy, obs.stage, obs.act, obs.rem, obs.tick, obs.done, obs.ab,
                         exp_v.busy, exp_v.stage, exp_v.act, exp_v.rem, exp_v.tick, exp_v.done, exp_v.ab);
            end
            abort = ((cut_kind == 1) && (c == cut_idx)) || (c == xa_idx);
            reset = (cut_kind == 2) && (c == cut_idx);
            if (c == ms_idx) begin
                start       = 1'b1;
                coffee_type = 2'(ms_type);
            end else begin
                start = 1'b0;
            end
            step();
            c++;
        end
        abort       = 1'b0;
        reset       = 1'b0;
        start       = 1'b0;
        coffee_type = 2'd0;
        expq.delete();
    endtask

    task automatic test_reset();
        exp_t obs;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            obs = observed();
            vectors++;
            if (obs !== idle_vec()) begin
                miscompares++;
                $display("FAIL reset_hold cycle %0d: got %b expected %b", i, obs, idle_vec());
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            obs = observed();
            vectors++;
            if (obs !== idle_vec()) begin
                miscompares++;
                $display("FAIL idle_quiet cycle %0d: got %b expected %b", i, obs, idle_vec());
            end
        end
    endtask

    task automatic test_espresso();
        run_brew("espresso", 0, -1, 0, -1, 0, -1);
    endtask

    task automatic test_latte();
        run_brew("latte", 3, -1, 0, -1, 0, -1);
    endtask

    task automatic test_abort();
        // cappuccino BREW occupies cycles 10..17; its third cycle is index 12
        run_brew("cappuccino_abort", 2, 12, 1, -1, 0, -1);
    endtask

    task automatic test_ignore_start();
        // espresso HEAT occupies cycles 6..9
        run_brew("espresso_midstart", 0, -1, 0, 7, 3, -1);
    endtask

    task automatic test_abort_in_done();
        // americano stages span 28 cycles, so entry 28 is DONE
        run_brew("americano_done_abort", 1, -1, 0, -1, 0, 28);
    endtask

    task automatic test_reset_midbrew();
        exp_t obs;
        // latte MILK occupies cycles 18..29
        run_brew("latte_reset", 3, 21, 2, -1, 0, -1);
        start       = 1'b1;
        abort       = 1'b1;
        coffee_type = 2'd3;
        step();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            obs = observed();
            vectors++;
            if (obs !== idle_vec()) begin
                miscompares++;
                $display("FAIL start_abort_idle cycle %0d: got %b expected %b", i, obs, idle_vec());
            end
            step();
        end
        run_brew("espresso_after", 0, -1, 0, -1, 0, -1);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        coffee_type = 2'd0;
        test_reset();
        test_espresso();
        test_latte();
        test_abort();
        test_ignore_start();
        test_abort_in_done();
        test_reset_midbrew();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
